store_data_buffer: RTL
======================

Name: store_data_buffer

Overview:
- Receiving end of the store-data path: consumes the per-lane store-data uops (storeSqN + shifted 32-bit data) produced by the store-data load stage.
- Holds store data in a circular buffer indexed by storeSqN and tracks a per-entry "loaded" bit.
- Drains committed, loaded entries in order to the memory write path.
- Sits between the store-data load stage and the store-queue/cache write port; honours branch mispredicts and full flushes.

Parameters:
- WIDTH, 2, number of store-data input lanes per cycle
- NUM_SQ, 16, buffer entries (power of two)
- SQN_W, 5, storeSqN width; equals log2(NUM_SQ)+1, with the MSB as the wrap bit

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- IN_branch_taken  in  1  branch resolution with redirect this cycle
- IN_branch_flush  in  1  full pipeline flush (with taken)
- IN_branch_storeSqN  in  SQN_W  youngest storeSqN that survives a non-flush branch
- IN_comSqN  in  SQN_W  entries with storeSqN signed-below this value are committed
- IN_alloc_valid  in  1  allocate one entry at tail
- OUT_allocSqN  out  SQN_W  storeSqN given to the allocation (current tail)
- OUT_full  out  1  count == NUM_SQ
- IN_stData_valid  in  WIDTH  per-lane data valid
- IN_stData_storeSqN  in  WIDTH*SQN_W  per-lane target storeSqN
- IN_stData_data  in  WIDTH*32  per-lane data, already byte-shifted
- OUT_drain_valid  out  1  head entry ready to write
- OUT_drain_storeSqN  out  SQN_W  head storeSqN
- OUT_drain_data  out  32  head data
- IN_drain_ready  in  1  consumer accepts the drain

Behaviour:
- State: head and tail (SQN_W bits each), data[NUM_SQ] (32b), loaded[NUM_SQ].
  - idx = sqN[SQN_W-2:0].
  - count = tail - head (mod 2^SQN_W).
  - All age compares use $signed(a - b) on SQN_W bits.
- Reset (rst_n=0 at posedge):
  - head = tail = 0; all loaded = 0; data don't-care.
  - Outputs after reset: OUT_drain_valid=0, OUT_full=0, OUT_allocSqN=0.
- Allocation:
  - If IN_alloc_valid && !OUT_full && !IN_branch_taken: tail += 1 next cycle, and loaded[idx(tail)] is cleared.
  - An allocation while OUT_full is dropped, and an assertion fires.
  - OUT_full is computed from registered count only. A same-cycle drain does not free a slot for a same-cycle allocation.
- Data write, per lane i:
  - Accept if valid, and $signed(sqN - head) >= 0, and $signed(sqN - tail) < 0.
  - Under a non-flush branch, additionally require $signed(sqN - IN_branch_storeSqN) <= 0.
  - Under flush: write only if $signed(sqN - IN_comSqN) < 0.
  - Accepted write: data[idx] <= data; loaded[idx] <= 1.
  - An out-of-window write is dropped, and an assertion fires.
  - Two lanes with the same sqN in one cycle is illegal (assertion); the higher lane wins.
- Branch (IN_branch_taken):
  - Non-flush: tail <= IN_branch_storeSqN + 1, clamped so that tail >= head. Discarded entries get loaded cleared.
  - Flush: tail <= IN_comSqN if $signed(IN_comSqN - head) > 0, else head.
  - A branch takes priority over allocation in the same cycle. Draining proceeds normally in the same cycle.
- Drain:
  - OUT_drain_valid = (count != 0) && loaded[idx(head)] && $signed(head - IN_comSqN) < 0.
  - OUT_drain_storeSqN = head; OUT_drain_data = data[idx(head)].
  - Drain outputs are combinational from registered state.
  - Fire = valid && ready → head += 1 and loaded[idx(head)] <= 0.
  - valid may deassert without fire only when a flush or branch removes the head; data and sqN stay stable while valid && !ready.
- Latency:
  - A data write at cycle t is visible on the drain at t+1. There is no same-cycle bypass.
  - Allocation at t: OUT_allocSqN and OUT_full reflect it at t+1.
- Wrap-around: pointers wrap mod 2^SQN_W. full ⇔ idx(head) == idx(tail) with differing MSBs.
- Reset mid-operation: all state reinitialised in one cycle; pending entries are lost.

Test Plan:
- Reset, allocate 3 (sqN 0,1,2), write lane0 sqN1=0xAABBCCDD and lane1 sqN0=0x11, IN_comSqN=2 → drain sqN0/0x11, then sqN1/0xAABBCCDD on consecutive cycles with ready=1; sqN2 is held (not loaded, not committed).
- Fill 16 entries → OUT_full=1. Allocate in the same cycle as a drain fire → allocation dropped. Next cycle full=0; allocation succeeds with OUT_allocSqN = 16 (wrap bit set, idx 0).
- Entries 0..5 allocated, branch non-flush with storeSqN=2, plus same-cycle writes to sqN 2 and 4 → tail=3, sqN2 loaded, sqN4 write dropped. A subsequent allocation returns sqN3 with loaded=0.
- Entries 0..7, comSqN=3, flush → tail=3. Entries 0..2 drain once loaded; the next allocation gets sqN3.
- Drain valid with ready=0 for 4 cycles → storeSqN and data remain stable. Fire on the 5th cycle → head advances by exactly 1.
- Assert rst_n=0 with 5 loaded entries → next cycle drain_valid=0, full=0, allocSqN=0. A stale write to sqN2 is rejected.

Source files
------------

// File: rtl/store_data_buffer.sv
// Store-data buffer: circular store of per-storeSqN data with loaded bits,
// draining committed, loaded entries in order to the memory write port.
module store_data_buffer #(
  parameter int WIDTH  = 2,
  parameter int NUM_SQ = 16,
  parameter int SQN_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   IN_branch_taken,
  input  logic                   IN_branch_flush,
  input  logic [SQN_W-1:0]       IN_branch_storeSqN,
  input  logic [SQN_W-1:0]       IN_comSqN,
  input  logic                   IN_alloc_valid,
  output logic [SQN_W-1:0]       OUT_allocSqN,
  output logic                   OUT_full,
  input  logic [WIDTH-1:0]       IN_stData_valid,
  input  logic [WIDTH*SQN_W-1:0] IN_stData_storeSqN,
  input  logic [WIDTH*32-1:0]    IN_stData_data,
  output logic                   OUT_drain_valid,
  output logic [SQN_W-1:0]       OUT_drain_storeSqN,
  output logic [31:0]            OUT_drain_data,
  input  logic                   IN_drain_ready
);
  localparam int IDX_W = SQN_W - 1;
  typedef logic [SQN_W-1:0] sqn_t;
  typedef logic [IDX_W-1:0] idx_t;

  sqn_t              head, tail, head_nxt, tail_nxt, br_tail, count, disc_cnt;
  logic [31:0]       data [NUM_SQ];
  logic [NUM_SQ-1:0] loaded, loaded_nxt, discard;
  sqn_t              lane_sqn [WIDTH];
  logic [WIDTH-1:0]  in_win, wr_en;
  logic              alloc_fire, drain_fire;
  idx_t              off;

  // Wrap-aware age compare: true when a is older than b, i.e. $signed(a - b) < 0.
  function automatic logic older(input sqn_t a, input sqn_t b);
    sqn_t d;
    d = a - b;
    return d[SQN_W-1];
  endfunction

  assign count              = tail - head;
  assign OUT_full           = (count == sqn_t'(NUM_SQ));
  assign OUT_allocSqN       = tail;
  assign OUT_drain_storeSqN = head;
  assign OUT_drain_data     = data[head[IDX_W-1:0]];
  assign OUT_drain_valid    = (count != '0) && loaded[head[IDX_W-1:0]] && older(head, IN_comSqN);

  always_comb begin
    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    drain_fire = OUT_drain_valid && IN_drain_ready;
    alloc_fire = IN_alloc_valid && !OUT_full && !IN_branch_taken;
    head_nxt   = drain_fire ? head + sqn_t'(1) : head;
    tail_nxt   = alloc_fire ? tail + sqn_t'(1) : tail;
    br_tail    = IN_branch_flush ? IN_comSqN : IN_branch_storeSqN + sqn_t'(1);
    if (IN_branch_taken) begin
      // Never shrink below the (post-drain) head nor grow past the allocated tail.
      if (older(br_tail, head_nxt)) br_tail = head_nxt;
      if (older(tail, br_tail))     br_tail = tail;
      tail_nxt = br_tail;
    end

    disc_cnt = tail - tail_nxt;
    discard  = '0;
    off      = '0;
    for (int j = 0; j < NUM_SQ; j++) begin
      off        = idx_t'(j) - tail_nxt[IDX_W-1:0];
      discard[j] = IN_branch_taken && ({1'b0, off} < disc_cnt);
    end

    for (int i = 0; i < WIDTH; i++) begin
      lane_sqn[i] = IN_stData_storeSqN[i*SQN_W +: SQN_W];
      in_win[i]   = !older(lane_sqn[i], head) && older(lane_sqn[i], tail);
      wr_en[i]    = IN_stData_valid[i] && in_win[i];
      if (IN_branch_taken && IN_branch_flush)
        wr_en[i] = wr_en[i] && older(lane_sqn[i], IN_comSqN);
      else if (IN_branch_taken)
        wr_en[i] = wr_en[i] && !older(IN_branch_storeSqN, lane_sqn[i]);
    end

    loaded_nxt = loaded;
    if (alloc_fire) loaded_nxt[tail[IDX_W-1:0]] = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (wr_en[i]) loaded_nxt[lane_sqn[i][IDX_W-1:0]] = 1'b1;
    loaded_nxt = loaded_nxt & ~discard;
    if (drain_fire) loaded_nxt[head[IDX_W-1:0]] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      loaded <= '0;
    end else begin
      head   <= head_nxt;
      tail   <= tail_nxt;
      loaded <= loaded_nxt;
      assert (!(IN_alloc_valid && OUT_full))
        else $warning("store_data_buffer: allocation while full dropped");
      for (int i = 0; i < WIDTH; i++) begin
        assert (!(IN_stData_valid[i] && !in_win[i]))
          else $warning("store_data_buffer: out-of-window store data dropped");
        for (int k = i + 1; k < WIDTH; k++)
          assert (!(IN_stData_valid[i] && IN_stData_valid[k] && lane_sqn[i] == lane_sqn[k]))
            else $warning("store_data_buffer: two lanes target one storeSqN");
      end
    end
  end

  // NOTE: the data array carries no reset; the loaded bits alone decide whether an entry is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++)
      if (wr_en[i]) data[lane_sqn[i][IDX_W-1:0]] <= IN_stData_data[i*32 +: 32];
  end

endmodule
